// File: rtl/stream_upsize_arb.sv
// stream_upsize_arb: packet-atomic round-robin arbiter feeding one shared stream_upsize input
// Ports:
//   clk, rst_n                                clock, asynchronous active-low reset
//   src_en_i                                  per-source enable, looked at only when arbitrating
//   s_data_i, s_last_i, s_valid_i, s_ready_o  N_SRC narrow source streams, source k data in [k*W +: W]
//   m_data_o, m_last_o, m_valid_o, m_ready_i  muxed stream towards the upsizer
//   grant_o                                   current or most recently granted source
//   busy_o                                    high while a packet is being forwarded
//   pkt_cnt_o                                 packets completed since reset, wrapping
module stream_upsize_arb #(
    parameter int T_DATA_WIDTH = 4,
    parameter int N_SRC        = 4,
    parameter int CNT_WIDTH    = 16,
    localparam int GW          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SRC-1:0]              src_en_i,
    input  logic [N_SRC*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [N_SRC-1:0]              s_last_i,
    input  logic [N_SRC-1:0]              s_valid_i,
    output logic [N_SRC-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]       m_data_o,
    output logic                          m_last_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [GW-1:0]                 grant_o,
    output logic                          busy_o,
    output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           grant, last_grant, arb_idx, cand;
    logic [N_SRC-1:0]        req;
    logic                    arb_hit, pkt_done;
    logic [T_DATA_WIDTH-1:0] src_data [N_SRC];

    for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
        assign src_data[k] = s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
    end

    assign req      = s_valid_i & src_en_i;
    assign pkt_done = m_valid_o & m_ready_i & m_last_o;
    assign grant_o  = grant;

    // Search starts just after the previous winner and wraps, so the last
    // served source has the lowest priority in the next round.
    always_comb begin
        arb_idx = grant;
        arb_hit = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = GW'((int'(last_grant) + i) % N_SRC);
            if (!arb_hit && req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // XFER always falls back to IDLE after the last beat, giving the one-cycle
    // arbitration gap between packets.
    always_comb begin
        state_nxt = (state == IDLE) ? (arb_hit ? XFER : IDLE) : (pkt_done ? IDLE : XFER);
    end

    always_comb begin
        busy_o           = (state == XFER);
        m_data_o         = src_data[grant];
        m_valid_o        = busy_o & s_valid_i[grant];
        m_last_o         = busy_o & s_last_i[grant];
        s_ready_o        = '0;
        s_ready_o[grant] = busy_o & m_ready_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            last_grant <= GW'(N_SRC - 1);
            pkt_cnt_o  <= '0;
        end else begin
            if (state == IDLE && arb_hit)
                grant <= arb_idx;
            if (pkt_done) begin
                last_grant <= grant;
                pkt_cnt_o  <= pkt_cnt_o + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_stream_upsize_arb.sv
// tb_stream_upsize_arb: randomized scoreboard bench for stream_upsize_arb
module tb_stream_upsize_arb;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int CW = 4;
    localparam int GW = 2;

    typedef struct { logic [W-1:0] d; logic l; } beat_t;
    typedef struct { int src; logic [W-1:0] d; logic l; } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   src_en_i = '1;
    logic [N*W-1:0] s_data_i = '0;
    logic [N-1:0]   s_last_i = '0;
    logic [N-1:0]   s_valid_i = '0;
    logic [N-1:0]   s_ready_o;
    logic [W-1:0]   m_data_o;
    logic           m_last_o, m_valid_o, busy_o;
    logic           m_ready_i = 1'b0;
    logic [GW-1:0]  grant_o;
    logic [CW-1:0]  pkt_cnt_o;

    int vectors = 0;
    int errors  = 0;

    beat_t srcq [N][$];
    exp_t  exp_q [$];
    exp_t  mon_e;

    logic [N-1:0] vld = '0, acc = '0, midpkt = '0;
    int   p_valid = 100, p_ready = 100, p_en = 0;
    logic drain = 1'b0;

    logic mbusy = 1'b0;
    int   mg = 0, mlast = N - 1, mcnt = 0, mrem = 0, mbeats = 0;

    always #5 clk = ~clk;

    stream_upsize_arb #(.T_DATA_WIDTH(W), .N_SRC(N), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .src_en_i(src_en_i),
        .s_data_i(s_data_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .grant_o(grant_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic gen_pkt(input int k);
        int len = $urandom_range(4, 1);
        for (int j = 0; j < len; j++) begin
            beat_t b;
            b.d = W'($urandom);
            b.l = (j == len - 1);
            srcq[k].push_back(b);
        end
    endtask

    // Sources: a raised valid is held until accepted; a fresh beat may be delayed.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                midpkt[k] = !srcq[k][0].l;
                void'(srcq[k].pop_front());
                vld[k] = 1'b0;
            end
            if (srcq[k].size() == 0)
                gen_pkt(k);
            if (!vld[k] && (drain ? midpkt[k] : ($urandom_range(99) < p_valid)))
                vld[k] = 1'b1;
            s_valid_i[k]       = vld[k];
            s_data_i[k*W +: W] = srcq[k][0].d;
            s_last_i[k]        = srcq[k][0].l;
        end
        m_ready_i = drain || ($urandom_range(99) < p_ready);
        if (drain)
            src_en_i = '1;
        else if ($urandom_range(99) < p_en)
            src_en_i = N'($urandom);
        acc = '0;
    endtask

    // Reference: whole packet of the round-robin winner is queued at the arbitration cycle.
    task automatic grant_pkt(input int k);
        mrem   = 0;
        mbeats = 0;
        for (int j = 0; j < srcq[k].size(); j++) begin
            exp_t e;
            e.src = k;
            e.d   = srcq[k][j].d;
            e.l   = srcq[k][j].l;
            exp_q.push_back(e);
            mrem++;
            if (srcq[k][j].l) break;
        end
        mbusy = 1'b1;
    endtask

    task automatic step();
        logic [N-1:0] req, erdy;
        logic         found;
        @(negedge clk);
        acc  = s_valid_i & s_ready_o;
        erdy = mbusy ? (N'(m_ready_i) << mg) : '0;
        chk("s_ready", s_ready_o, erdy);
        chk("busy", busy_o, mbusy);
        chk("m_valid", m_valid_o, mbusy && s_valid_i[mg]);
        chk("m_last", m_last_o, mbusy && s_last_i[mg]);
        chk("grant", grant_o, mg);
        chk("pkt_cnt", pkt_cnt_o, mcnt);
        if (mbusy) begin
            if (s_valid_i[mg] && m_ready_i) begin
                mbeats++;
                mrem--;
                if (mrem == 0) begin
                    mbusy = 1'b0;
                    mlast = mg;
                    mcnt  = (mcnt + 1) % (1 << CW);
                end
            end
        end else begin
            req   = s_valid_i & src_en_i;
            found = 1'b0;
            for (int i = 1; i <= N; i++) begin
                if (!found && req[(mlast + i) % N]) begin
                    found = 1'b1;
                    mg    = (mlast + i) % N;
                end
            end
            if (found)
                grant_pkt(mg);
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int pv, input int pr, input int pe, input logic [N-1:0] en, input int n);
        p_valid  = pv;
        p_ready  = pr;
        p_en     = pe;
        src_en_i = en;
        repeat (n) step();
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL beat: unexpected beat data %0h from grant %0d, none expected", m_data_o, grant_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_src", grant_o, mon_e.src);
                chk("beat_data", m_data_o, mon_e.d);
                chk("beat_last", m_last_o, mon_e.l);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_pkt_cnt", pkt_cnt_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive();

        run(100, 100, 0, 4'b1111, 60);
        run(100, 100, 0, 4'b1011, 60);
        run(100, 50, 0, 4'b1111, 200);
        run(60, 70, 20, 4'b1111, 600);

        p_valid  = 100;
        p_ready  = 100;
        p_en     = 0;
        src_en_i = '1;
        for (int i = 0; i < 100 && !(mbusy && mbeats > 0 && mrem > 0); i++) step();
        chk("rst_setup_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", s_ready_o, 0);
        chk("midrst_m_valid", m_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_grant", grant_o, 0);
        chk("midrst_pkt_cnt", pkt_cnt_o, 0);
        exp_q.delete();
        for (int k = 0; k < N; k++) srcq[k].delete();
        mbusy     = 1'b0;
        mg        = 0;
        mlast     = N - 1;
        mcnt      = 0;
        mrem      = 0;
        vld       = '0;
        acc       = '0;
        midpkt    = '0;
        s_valid_i = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive();
        step();
        chk("first_after_rst", grant_o, 0);

        run(70, 60, 10, 4'b1111, 300);

        drain = 1'b1;
        for (int i = 0; i < 300 && (mbusy || vld != '0); i++) step();
        chk("drained", mbusy || vld != '0, 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
